lum_sensor_reader: RTL and testbench
====================================

# lum_sensor_reader

Front end that produces the 8-bit `Lum_sen` brightness value consumed by `ext_lights`. It drives a serial light-sensor ADC with chip-select and serial clock, shifting in 8-bit conversions MSB-first on a fixed sample period. It filters the conversions with a power-of-two moving average and presents the result with a one-cycle update strobe. It sits between the external sensor pins and the lighting controllers in the smart-home top level.

## Interface
- `SAMPLE_PERIOD`, 64: CLK cycles from one conversion start to the next.
- `CLK_DIV`, 2: CLK cycles per Adc_sclk half-period. Must be ≥1.
- `AVG_LOG2`, 2: the moving average spans 2^AVG_LOG2 conversions.
- `CLK  in  1`: single clock; all logic is on the rising edge.
- `Reset  in  1`: synchronous, active-low reset.
- `Enable  in  1`: when high, conversions run periodically.
- `Adc_miso  in  1`: serial data from the ADC, MSB first.
- `Adc_cs_n  out  1`: ADC chip select, active low.
- `Adc_sclk  out  1`: ADC serial clock, idles low.
- `Lum_sen  out  8`: filtered brightness value.
- `Lum_valid  out  1`: one-cycle pulse when `Lum_sen` updates.
- `Busy  out  1`: high while a frame is in progress, i.e. the FSM is in SELECT, SHIFT or DONE.

## Operation
- FSM states:
  - IDLE: `Adc_cs_n`=1, `Adc_sclk`=0.
    - Enable=1 → SELECT on the next cycle, with no period wait.
  - SELECT: `Adc_cs_n`=0, `Adc_sclk`=0, lasts CLK_DIV cycles → SHIFT.
  - SHIFT: 8 bits. Each bit is CLK_DIV cycles with SCLK low, then CLK_DIV cycles with SCLK high.
    - `Adc_miso` is captured on the same CLK edge that drives `Adc_sclk` from 0 to 1.
    - After the 8th high phase → DONE.
  - DONE: 1 cycle, `Adc_cs_n`=1. The averager absorbs the sample.
    - Exit to WAIT if Enable=1, otherwise to IDLE.
  - WAIT: `Adc_cs_n`=1. Waits until the period counter reaches SAMPLE_PERIOD, then → SELECT.
    - Enable=0 while in WAIT → IDLE.
- Period counter:
  - Cleared on entry to SELECT.
  - If SAMPLE_PERIOD is shorter than the frame, WAIT lasts 0 cycles: DONE goes straight to SELECT. Frames never overlap.
- Enable falling mid-frame: the current frame completes, including DONE and the `Lum_valid` pulse, then the FSM goes to IDLE.
- Averager:
  - Holds a ring of 2^AVG_LOG2 8-bit entries and a running sum of 8+AVG_LOG2 bits. The sum cannot overflow.
  - First sample after reset: every entry is prefilled with it and sum = sample<<AVG_LOG2, so the first output equals the raw sample.
  - Later samples: sum = sum − oldest + new; the new sample overwrites the oldest entry.
  - `Lum_sen` = sum>>AVG_LOG2, truncated with no rounding.
- `Lum_sen` holds its value between updates.

## Timing
- Reset values: `Adc_cs_n`=1, `Adc_sclk`=0, `Lum_sen`=0, `Lum_valid`=0, `Busy`=0.
  - State goes to IDLE, and the averager returns to "empty", so the next sample prefills.
- Reset mid-frame: outputs take their reset values on the reset edge and the partial frame is discarded.
- `Adc_cs_n` is low for exactly 17·CLK_DIV cycles per frame (34 at default).
- `Adc_sclk` shows exactly 8 rising edges per frame.
- `Lum_sen` and `Lum_valid` are registered at the end of DONE, so they are visible the cycle after DONE.
  - Latency from the `Adc_cs_n` falling edge to `Lum_valid` is 17·CLK_DIV+2 cycles (36 at default).
- `Adc_cs_n` falling edges are exactly max(SAMPLE_PERIOD, 17·CLK_DIV+1) cycles apart while Enable=1.
- All outputs are driven directly from flops.

## Structure
- Shared package `smart_home_pkg` holds:
  - `LUM_W` = 8, shared with `ext_lights`.
  - The FSM state encoding (IDLE, WAIT, SELECT, SHIFT, DONE).
- Sub-module `lum_avg` contains:
  - ring buffer, write pointer, running sum and prefill flag;
  - inputs: sample and sample strobe; outputs: average and valid.
- The top level contains the FSM, the period, phase and bit counters, and the shift register.

## Test plan
- Reset: hold `Reset`=0 for 2 cycles → `Lum_sen`=0, `Lum_valid`=0, `Adc_cs_n`=1, `Adc_sclk`=0, `Busy`=0.
- Single frame at default parameters, with an ADC model returning 90 (0x5A) → 8 SCLK rising edges, `Adc_cs_n` low for 34 cycles, one `Lum_valid` pulse with `Lum_sen`=90.
- Averaging with ADC samples 90,20,20,20,20 → `Lum_sen` sequence 90, 72, 55, 37, 20.
- Period with SAMPLE_PERIOD=64 → `Adc_cs_n` falling edges exactly 64 cycles apart.
  - With SAMPLE_PERIOD=10 → frames run back-to-back with `Adc_cs_n` high for exactly 1 cycle between them.
- Enable dropped during bit 3 → frame completes, `Lum_valid` pulses, no further `Adc_cs_n` falling edge, `Busy`=0.
- `Reset` asserted during bit 4 → on the next edge `Adc_cs_n`=1 and `Lum_sen`=0. The next frame with ADC value 200 gives `Lum_sen`=200, confirming prefill.

Source files
------------

// File: rtl/smart_home_pkg.sv
`default_nettype none
// ============================================================================
// Module : smart_home_pkg
// Brief  : Shared constants and the luminance-reader FSM state encoding.
// Rev    : 1.0
// ============================================================================
package smart_home_pkg;

    localparam int LUM_W      = 8;
    localparam int c_ADC_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SELECT = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_DONE   = 3'd4
    } lum_state_t;

    function automatic logic is_frame_state(input lum_state_t s);
        return (s == ST_SELECT) || (s == ST_SHIFT) || (s == ST_DONE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lum_avg.sv
`default_nettype none
// ============================================================================
// Module : lum_avg
// Brief  : Power-of-two moving average with first-sample prefill.
// Rev    : 1.0
// ============================================================================
module lum_avg
    import smart_home_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LUM_W-1:0] i_sample,
    input  logic             i_sample_stb,
    output logic [LUM_W-1:0] o_avg,
    output logic             o_valid
);

    localparam int c_DEPTH = 1 << AVG_LOG2;
    localparam int c_SUM_W = LUM_W + AVG_LOG2;
    localparam int c_PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    logic [LUM_W-1:0]   r_ring [c_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_SUM_W-1:0] r_sum;
    logic               r_primed;
    logic [LUM_W-1:0]   r_avg;
    logic               r_valid;

    logic [LUM_W-1:0]   w_oldest;
    logic [c_SUM_W-1:0] w_sum_next;
    logic [c_PTR_W-1:0] w_ptr_inc;

    always_comb begin
        w_oldest  = r_ring[r_wr_ptr];
        w_ptr_inc = (r_wr_ptr == c_PTR_W'(c_DEPTH - 1)) ? '0 : r_wr_ptr + c_PTR_W'(1);
        // Until primed the ring content is meaningless, so the sum restarts
        // from the sample replicated across every slot.
        if (!r_primed) begin
            w_sum_next = c_SUM_W'(i_sample) << AVG_LOG2;
        end else begin
            w_sum_next = r_sum - c_SUM_W'(w_oldest) + c_SUM_W'(i_sample);
        end
    end

    // Ring storage carries no reset; the prefill flag guards its contents.
    always_ff @(posedge clk) begin
        if (i_sample_stb) begin
            if (!r_primed) begin
                for (int i = 0; i < c_DEPTH; i++) begin
                    r_ring[i] <= i_sample;
                end
            end else begin
                r_ring[r_wr_ptr] <= i_sample;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_primed <= 1'b0;
            r_sum    <= '0;
            r_wr_ptr <= '0;
            r_avg    <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= i_sample_stb;
            if (i_sample_stb) begin
                r_primed <= 1'b1;
                r_sum    <= w_sum_next;
                r_avg    <= LUM_W'(w_sum_next >> AVG_LOG2);
                if (r_primed) begin
                    r_wr_ptr <= w_ptr_inc;
                end
            end
        end
    end

    assign o_avg   = r_avg;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/lum_sensor_reader.sv
`default_nettype none
// ============================================================================
// Module : lum_sensor_reader
// Brief  : Serial light-sensor ADC front end with periodic sampling and a
//          moving-average filter feeding the Lum_sen brightness value.
// Rev    : 1.0
// ============================================================================
module lum_sensor_reader
    import smart_home_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 64,
    parameter int CLK_DIV       = 2,
    parameter int AVG_LOG2      = 2
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Adc_miso,
    output logic             Adc_cs_n,
    output logic             Adc_sclk,
    output logic [LUM_W-1:0] Lum_sen,
    output logic             Lum_valid,
    output logic             Busy
);

    localparam int c_PHASE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_PER_W   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD + 1) : 1;
    localparam int c_BIT_W   = $clog2(c_ADC_BITS);

    lum_state_t              r_state;
    logic [c_PHASE_W-1:0]    r_phase;
    logic                    r_sclk_hi;
    logic [c_BIT_W-1:0]      r_bit;
    logic [c_PER_W-1:0]      r_period_cnt;
    logic [c_ADC_BITS-1:0]   r_shift;
    logic                    r_cs_n;
    logic                    r_sclk;
    logic                    r_busy;

    lum_state_t              w_state_next;
    logic [c_PHASE_W-1:0]    w_phase_next;
    logic                    w_sclk_hi_next;
    logic [c_BIT_W-1:0]      w_bit_next;
    logic                    w_phase_last;
    logic                    w_period_done;
    logic                    w_capture;
    logic                    w_period_clear;
    logic                    w_sample_stb;

    // Counter starts at 0 in the first SELECT cycle, so reaching
    // SAMPLE_PERIOD-1 means the next cycle starts a new frame on schedule.
    assign w_period_done = (r_period_cnt >= c_PER_W'(SAMPLE_PERIOD - 1));
    assign w_phase_last  = (r_phase == c_PHASE_W'(CLK_DIV - 1));
    assign w_sample_stb  = (r_state == ST_DONE);

    always_comb begin
        w_state_next   = r_state;
        w_phase_next   = '0;
        w_sclk_hi_next = r_sclk_hi;
        w_bit_next     = r_bit;
        w_capture      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (Enable) begin
                    w_state_next = ST_SELECT;
                end
            end
            ST_WAIT: begin
                if (!Enable) begin
                    w_state_next = ST_IDLE;
                end else if (w_period_done) begin
                    w_state_next = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (w_phase_last) begin
                    w_state_next   = ST_SHIFT;
                    w_sclk_hi_next = 1'b0;
                    w_bit_next     = '0;
                end else begin
                    w_phase_next = r_phase + c_PHASE_W'(1);
                end
            end
            ST_SHIFT: begin
                if (!w_phase_last) begin
                    w_phase_next = r_phase + c_PHASE_W'(1);
                end else if (!r_sclk_hi) begin
                    w_sclk_hi_next = 1'b1;
                    w_capture      = 1'b1;
                end else begin
                    w_sclk_hi_next = 1'b0;
                    if (r_bit == c_BIT_W'(c_ADC_BITS - 1)) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_bit_next = r_bit + c_BIT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (!Enable) begin
                    w_state_next = ST_IDLE;
                end else if (w_period_done) begin
                    w_state_next = ST_SELECT;
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        w_period_clear = (w_state_next == ST_SELECT) && (r_state != ST_SELECT);
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_state      <= ST_IDLE;
            r_phase      <= '0;
            r_sclk_hi    <= 1'b0;
            r_bit        <= '0;
            r_period_cnt <= '0;
            r_shift      <= '0;
            r_cs_n       <= 1'b1;
            r_sclk       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_phase   <= w_phase_next;
            r_sclk_hi <= w_sclk_hi_next;
            r_bit     <= w_bit_next;

            if (w_period_clear) begin
                r_period_cnt <= '0;
            end else if (!w_period_done) begin
                r_period_cnt <= r_period_cnt + c_PER_W'(1);
            end

            if (w_capture) begin
                r_shift <= {r_shift[c_ADC_BITS-2:0], Adc_miso};
            end

            // Pin outputs are registered from the next state so they line up
            // with the state register cycle-for-cycle.
            r_cs_n <= !((w_state_next == ST_SELECT) || (w_state_next == ST_SHIFT));
            r_sclk <= (w_state_next == ST_SHIFT) && w_sclk_hi_next;
            r_busy <= is_frame_state(w_state_next);
        end
    end

    lum_avg #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_lum_avg (
        .clk          (CLK),
        .rst_n        (Reset),
        .i_sample     (r_shift),
        .i_sample_stb (w_sample_stb),
        .o_avg        (Lum_sen),
        .o_valid      (Lum_valid)
    );

    assign Adc_cs_n = r_cs_n;
    assign Adc_sclk = r_sclk;
    assign Busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_lum_sensor_reader.sv
`default_nettype none
// ============================================================================
// Module : tb_lum_sensor_reader
// Brief  : Self-checking bench: ADC pin model, moving-average reference.
// Rev    : 1.0
// ============================================================================
module tb_lum_sensor_reader;

    localparam int P_A     = 64;
    localparam int P_B     = 10;
    localparam int DIV     = 2;
    localparam int ALOG    = 2;
    localparam int NAVG    = 1 << ALOG;
    localparam int FRAME   = 17 * DIV + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       adc_miso = 1'b0;
    logic       adc_cs_n, adc_sclk, lum_valid, busy;
    logic [7:0] lum_sen;

    logic       reset_b = 1'b0;
    logic       enable_b = 1'b0;
    logic       miso_b = 1'b1;
    logic       cs_n_b, sclk_b, valid_b, busy_b;
    logic [7:0] lum_b;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lum_sensor_reader #(.SAMPLE_PERIOD(P_A), .CLK_DIV(DIV), .AVG_LOG2(ALOG)) dut (
        .CLK(clk), .Reset(reset), .Enable(enable), .Adc_miso(adc_miso),
        .Adc_cs_n(adc_cs_n), .Adc_sclk(adc_sclk), .Lum_sen(lum_sen),
        .Lum_valid(lum_valid), .Busy(busy)
    );

    lum_sensor_reader #(.SAMPLE_PERIOD(P_B), .CLK_DIV(DIV), .AVG_LOG2(ALOG)) dut_b (
        .CLK(clk), .Reset(reset_b), .Enable(enable_b), .Adc_miso(miso_b),
        .Adc_cs_n(cs_n_b), .Adc_sclk(sclk_b), .Lum_sen(lum_b),
        .Lum_valid(valid_b), .Busy(busy_b)
    );

    // ---------------- ADC model and monitor for the main instance ----------
    logic [7:0] adc_q[$];
    logic [7:0] hist[$];
    logic [7:0] valid_q[$];
    int         valid_cyc_q[$];
    int         cs_fall_q[$];
    int         frame_low_q[$];
    int         frame_sclk_q[$];
    logic [7:0] cur_sample = 8'd0;
    int         bit_idx = 0;
    int         cs_low = 0;
    int         sclk_rises = 0;
    logic       prev_cs = 1'b1;
    logic       prev_sclk = 1'b0;

    always @(negedge clk) begin
        if (prev_cs === 1'b1 && adc_cs_n === 1'b0) begin
            if (adc_q.size() > 0) cur_sample = adc_q.pop_front();
            else                  cur_sample = 8'($urandom_range(0, 255));
            hist.push_back(cur_sample);
            cs_fall_q.push_back(cyc);
            bit_idx    = 7;
            adc_miso   = cur_sample[7];
            cs_low     = 0;
            sclk_rises = 0;
        end
        if (adc_cs_n === 1'b0) cs_low++;
        if (prev_cs === 1'b0 && adc_cs_n === 1'b1) begin
            frame_low_q.push_back(cs_low);
            frame_sclk_q.push_back(sclk_rises);
        end
        if (prev_sclk === 1'b0 && adc_sclk === 1'b1) sclk_rises++;
        // ADC shifts its next bit out on the falling SCLK edge.
        if (prev_sclk === 1'b1 && adc_sclk === 1'b0 && bit_idx > 0) begin
            bit_idx--;
            adc_miso = cur_sample[bit_idx];
        end
        if (lum_valid === 1'b1) begin
            valid_q.push_back(lum_sen);
            valid_cyc_q.push_back(cyc);
        end
        prev_cs   = adc_cs_n;
        prev_sclk = adc_sclk;
    end

    // ---------------- monitor for the short-period instance ----------------
    int   b_fall_q[$];
    int   b_gap_q[$];
    int   b_high_run = 0;
    logic b_seen = 1'b0;
    logic b_prev_cs = 1'b1;

    always @(negedge clk) begin
        if (b_prev_cs === 1'b1 && cs_n_b === 1'b0) begin
            if (b_seen) b_gap_q.push_back(b_high_run);
            b_seen = 1'b1;
            b_high_run = 0;
            b_fall_q.push_back(cyc);
        end
        if (cs_n_b === 1'b1) b_high_run++;
        b_prev_cs = cs_n_b;
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        adc_q.delete();
        valid_q.delete();
        valid_cyc_q.delete();
        cs_fall_q.delete();
        frame_low_q.delete();
        frame_sclk_q.delete();
    endtask

    // Reference: mean of the last NAVG samples since reset, where slots
    // before the first sample are taken to hold that first sample.
    function automatic int exp_avg(int k);
        int s;
        s = 0;
        for (int j = 0; j < NAVG; j++) begin
            int idx;
            idx = k - j;
            if (idx < 0) idx = 0;
            s += int'(hist[idx]);
        end
        return s / NAVG;
    endfunction

    task automatic wait_valid(input int count, input int budget, input string name);
        int n;
        n = 0;
        while (valid_q.size() < count && n < budget) begin
            step();
            n++;
        end
        if (valid_q.size() < count) begin
            n_checks++;
            $display("FAIL %s timeout: got %0d valid pulses, required %0d", name, valid_q.size(), count);
        end
    endtask

    task automatic wait_bit(input int idx, input string name);
        int n;
        n = 0;
        while (!(cs_fall_q.size() > 0 && bit_idx == idx && adc_cs_n === 1'b0) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) begin
            n_checks++;
            $display("FAIL %s timeout waiting for bit index %0d", name, idx);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        enable = 1'b0;
        repeat (2) step();
        n_checks++; if (lum_sen !== 8'd0) $display("FAIL reset_lum got %0d want 0", lum_sen); else n_pass++;
        n_checks++; if (lum_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", lum_valid); else n_pass++;
        n_checks++; if (adc_cs_n !== 1'b1) $display("FAIL reset_cs_n got %b want 1", adc_cs_n); else n_pass++;
        n_checks++; if (adc_sclk !== 1'b0) $display("FAIL reset_sclk got %b want 0", adc_sclk); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        reset = 1'b1;
        step();
        clear_mon();
    endtask

    task automatic test_single_frame();
        int v, lat;
        clear_mon();
        adc_q.push_back(8'd90);
        enable = 1'b1;
        wait_valid(1, 200, "single_frame");
        step();
        enable = 1'b0;
        repeat (80) step();
        v = (frame_sclk_q.size() > 0) ? frame_sclk_q[0] : -1;
        n_checks++; if (v !== 8) $display("FAIL single_sclk_edges got %0d want 8", v); else n_pass++;
        v = (frame_low_q.size() > 0) ? frame_low_q[0] : -1;
        n_checks++; if (v !== 17 * DIV) $display("FAIL single_cs_low got %0d want %0d", v, 17 * DIV); else n_pass++;
        n_checks++; if (valid_q.size() !== 1) $display("FAIL single_pulses got %0d want 1", valid_q.size()); else n_pass++;
        v = (valid_q.size() > 0) ? int'(valid_q[0]) : -1;
        n_checks++; if (v !== 90) $display("FAIL single_lum got %0d want 90", v); else n_pass++;
        // Count of cycles from the first cs-low cycle through the valid cycle.
        lat = (valid_cyc_q.size() > 0 && cs_fall_q.size() > 0) ? valid_cyc_q[0] - cs_fall_q[0] + 1 : -1;
        n_checks++; if (lat !== 17 * DIV + 2) $display("FAIL single_latency got %0d want %0d", lat, 17 * DIV + 2); else n_pass++;
        n_checks++; if (lum_sen !== 8'd90) $display("FAIL single_hold got %0d want 90", lum_sen); else n_pass++;
        n_checks++; if (busy !== 1'b0 || adc_cs_n !== 1'b1) $display("FAIL single_idle got busy=%b cs_n=%b want 0/1", busy, adc_cs_n); else n_pass++;
    endtask

    task automatic test_averaging();
        int exp_seq[4] = '{72, 55, 37, 20};
        int v;
        clear_mon();
        repeat (4) adc_q.push_back(8'd20);
        enable = 1'b1;
        wait_valid(4, 400, "averaging");
        step();
        enable = 1'b0;
        repeat (80) step();
        for (int i = 0; i < 4; i++) begin
            v = (valid_q.size() > i) ? int'(valid_q[i]) : -1;
            n_checks++;
            if (v !== exp_seq[i]) $display("FAIL avg_seq[%0d] got %0d want %0d", i, v, exp_seq[i]); else n_pass++;
        end
    endtask

    task automatic test_period();
        int base, v, e;
        clear_mon();
        base = hist.size();
        repeat (6) adc_q.push_back(8'($urandom_range(0, 255)));
        enable = 1'b1;
        wait_valid(6, 800, "period");
        step();
        enable = 1'b0;
        repeat (80) step();
        for (int i = 0; i < 6; i++) begin
            v = (valid_q.size() > i) ? int'(valid_q[i]) : -1;
            e = (hist.size() > base + i) ? exp_avg(base + i) : -2;
            n_checks++;
            if (v !== e) $display("FAIL period_avg[%0d] got %0d want %0d", i, v, e); else n_pass++;
        end
        for (int i = 0; i < 5; i++) begin
            v = (cs_fall_q.size() > i + 1) ? cs_fall_q[i + 1] - cs_fall_q[i] : -1;
            e = (P_A > FRAME) ? P_A : FRAME;
            n_checks++;
            if (v !== e) $display("FAIL period_spacing[%0d] got %0d want %0d", i, v, e); else n_pass++;
        end
    endtask

    task automatic test_enable_drop();
        int base, v, e;
        clear_mon();
        base = hist.size();
        adc_q.push_back(8'($urandom_range(0, 255)));
        enable = 1'b1;
        wait_bit(5, "enable_drop");
        enable = 1'b0;
        repeat (120) step();
        n_checks++; if (valid_q.size() !== 1) $display("FAIL drop_pulses got %0d want 1", valid_q.size()); else n_pass++;
        v = (valid_q.size() > 0) ? int'(valid_q[0]) : -1;
        e = (hist.size() > base) ? exp_avg(base) : -2;
        n_checks++; if (v !== e) $display("FAIL drop_lum got %0d want %0d", v, e); else n_pass++;
        v = (frame_sclk_q.size() > 0) ? frame_sclk_q[0] : -1;
        n_checks++; if (v !== 8) $display("FAIL drop_sclk_edges got %0d want 8", v); else n_pass++;
        v = (frame_low_q.size() > 0) ? frame_low_q[0] : -1;
        n_checks++; if (v !== 17 * DIV) $display("FAIL drop_cs_low got %0d want %0d", v, 17 * DIV); else n_pass++;
        n_checks++; if (cs_fall_q.size() !== 1) $display("FAIL drop_frames got %0d want 1", cs_fall_q.size()); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL drop_busy got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        int v, e;
        clear_mon();
        enable = 1'b1;
        wait_bit(4, "reset_mid");
        reset = 1'b0;
        step();
        n_checks++; if (adc_cs_n !== 1'b1) $display("FAIL rmid_cs_n got %b want 1", adc_cs_n); else n_pass++;
        n_checks++; if (adc_sclk !== 1'b0) $display("FAIL rmid_sclk got %b want 0", adc_sclk); else n_pass++;
        n_checks++; if (lum_sen !== 8'd0) $display("FAIL rmid_lum got %0d want 0", lum_sen); else n_pass++;
        n_checks++; if (lum_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", lum_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else n_pass++;
        step();
        clear_mon();
        hist.delete();
        adc_q.push_back(8'd200);
        adc_q.push_back(8'($urandom_range(0, 255)));
        reset = 1'b1;
        wait_valid(2, 300, "reset_mid_refill");
        step();
        enable = 1'b0;
        repeat (80) step();
        v = (valid_q.size() > 0) ? int'(valid_q[0]) : -1;
        n_checks++; if (v !== 200) $display("FAIL rmid_prefill got %0d want 200", v); else n_pass++;
        v = (valid_q.size() > 1) ? int'(valid_q[1]) : -1;
        e = (hist.size() > 1) ? exp_avg(1) : -2;
        n_checks++; if (v !== e) $display("FAIL rmid_second got %0d want %0d", v, e); else n_pass++;
        n_checks++; if (valid_q.size() !== 2) $display("FAIL rmid_pulses got %0d want 2", valid_q.size()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int v, n, e;
        reset_b = 1'b1;
        step();
        b_fall_q.delete();
        b_gap_q.delete();
        b_seen = 1'b0;
        enable_b = 1'b1;
        n = 0;
        while (b_fall_q.size() < 4 && n < 400) begin
            step();
            n++;
        end
        if (b_fall_q.size() < 4) begin
            n_checks++;
            $display("FAIL b2b timeout: got %0d frames, required 4", b_fall_q.size());
        end
        enable_b = 1'b0;
        repeat (60) step();
        e = (P_B > FRAME) ? P_B : FRAME;
        for (int i = 0; i < 3; i++) begin
            v = (b_fall_q.size() > i + 1) ? b_fall_q[i + 1] - b_fall_q[i] : -1;
            n_checks++;
            if (v !== e) $display("FAIL b2b_spacing[%0d] got %0d want %0d", i, v, e); else n_pass++;
            v = (b_gap_q.size() > i) ? b_gap_q[i] : -1;
            n_checks++;
            if (v !== 1) $display("FAIL b2b_gap[%0d] got %0d want 1", i, v); else n_pass++;
        end
        n_checks++; if (lum_b !== 8'd255) $display("FAIL b2b_lum got %0d want 255", lum_b); else n_pass++;
        n_checks++; if (busy_b !== 1'b0) $display("FAIL b2b_busy got %b want 0", busy_b); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_averaging();
        test_period();
        test_enable_drop();
        test_reset_midframe();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
